// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped UART for the MEM-stage data bus.
//
// Registers (byte addresses):
//   BASE_ADDR + 0  TXD  [7:0]  write starts a frame (ignored while busy), reads back TXD
//   BASE_ADDR + 4  RXD  [7:0]  last received byte, read-only
//   BASE_ADDR + 8  CON  bit0 tx_int_en, bit1 rx_int_en (RW), bit2 tx_done,
//                       bit3 rx_ready, bit4 tx_busy, bit5 rx_overrun, bit6 rx_err
//
// Ports:
//   clk, reset      system clock, asynchronous active-high reset
//   rd, wr          bus strobes (MemRd / MemWr)
//   addr, wdata     byte address and store data
//   rdata           read data, zero unless a register is read (OR-able bus)
//   rx, tx          serial in (asynchronous, idle high) / serial out (idle high)
//   irq             level interrupt request, registered
//
// Build option: define UART_PARITY_EN for 8E1 frames (even parity bit after D7);
// without it frames are 8N1.

module uart_mmio #(
  parameter int unsigned BAUD_DIV  = 5208,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0018
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        rx,
  output logic        tx,
  output logic        irq
);

  localparam int unsigned CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0, ST_START = 3'd1, ST_DATA = 3'd2, ST_STOP = 3'd3, ST_PARITY = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0, ST_START = 3'd1, ST_DATA = 3'd2, ST_STOP = 3'd3
  } state_e;
`endif

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

  state_e           tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d, txd_q, txd_d;
  logic [7:0]       rx_shift_q, rx_shift_d, rxd_q, rxd_d;
  logic [1:0]       int_en_q, int_en_d;
  logic             tx_q, tx_d, irq_q, irq_d;
  logic             tx_done_q, tx_done_d, rx_ready_q, rx_ready_d;
  logic             rx_overrun_q, rx_overrun_d, rx_err_q, rx_err_d;
  logic             rx_meta_q, rx_sync_q, rx_prev_q;
`ifdef UART_PARITY_EN
  logic             rx_perr_q, rx_perr_d;
`endif
  logic sel_txd_s, sel_rxd_s, sel_con_s, txd_wr_s, con_rd_s, rxd_rd_s, tx_busy_s;
  logic tx_done_set_s, rx_ok_s, rx_bad_s, rx_fall_s;
  logic unused_wdata_s;

  assign unused_wdata_s = ^wdata[31:8];

  assign sel_txd_s = (addr == BASE_ADDR);
  assign sel_rxd_s = (addr == BASE_ADDR + 32'd4);
  assign sel_con_s = (addr == BASE_ADDR + 32'd8);
  // A TXD write is only accepted when the transmitter is idle.
  assign txd_wr_s  = wr & sel_txd_s & (tx_state_q == ST_IDLE);
  assign con_rd_s  = rd & sel_con_s;
  assign rxd_rd_s  = rd & sel_rxd_s;
  assign tx_busy_s = (tx_state_q != ST_IDLE);
  assign rx_fall_s = rx_prev_q & ~rx_sync_q;
  assign tx        = tx_q;
  assign irq       = irq_q;

  // Read mux: combinational, zero when not reading a mapped register
  always_comb begin
    rdata = 32'd0;
    if (rd && sel_txd_s) begin
      rdata = {24'd0, txd_q};
    end else if (rd && sel_rxd_s) begin
      rdata = {24'd0, rxd_q};
    end else if (rd && sel_con_s) begin
      rdata = {25'd0, rx_err_q, rx_overrun_q, tx_busy_s, rx_ready_q, tx_done_q, int_en_q};
    end else begin
      rdata = 32'd0;
    end
  end

  // Transmit FSM next state; tx_d is the line level for the state being entered
  always_comb begin
    tx_state_d    = tx_state_q;
    tx_cnt_d      = tx_cnt_q;
    tx_bit_d      = tx_bit_q;
    tx_shift_d    = tx_shift_q;
    txd_d         = txd_q;
    tx_done_set_s = 1'b0;
    case (tx_state_q)
      ST_IDLE: begin
        tx_cnt_d = '0;
        if (txd_wr_s) begin
          txd_d      = wdata[7:0];
          tx_shift_d = wdata[7:0];
          tx_state_d = ST_START;
        end else begin
          tx_state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = 3'd0;
          tx_state_d = ST_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            tx_state_d = ST_PARITY;
`else
            tx_state_d = ST_STOP;
`endif
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
`ifdef UART_PARITY_EN
      ST_PARITY: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = ST_STOP;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
`endif
      ST_STOP: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d      = '0;
          tx_state_d    = ST_IDLE;
          tx_done_set_s = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      default: begin
        tx_state_d = ST_IDLE;
        tx_cnt_d   = '0;
      end
    endcase

    case (tx_state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = tx_shift_d[0];
`ifdef UART_PARITY_EN
      ST_PARITY: tx_d = even_parity(txd_q);
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  // Receive FSM next state; samples the synchronised line mid-bit
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_ok_s    = 1'b0;
    rx_bad_s   = 1'b0;
`ifdef UART_PARITY_EN
    rx_perr_d  = rx_perr_q;
`endif
    case (rx_state_q)
      ST_IDLE: begin
        rx_cnt_d = '0;
        if (rx_fall_s) begin
          rx_state_d = ST_START;
        end else begin
          rx_state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (rx_cnt_q == CNT_MID) begin
          rx_cnt_d = '0;
          rx_bit_d = 3'd0;
          // Line back high at mid-start: a glitch, drop it silently.
          if (rx_sync_q) begin
            rx_state_d = ST_IDLE;
          end else begin
            rx_state_d = ST_DATA;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            rx_state_d = ST_PARITY;
`else
            rx_state_d = ST_STOP;
`endif
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
`ifdef UART_PARITY_EN
      ST_PARITY: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d   = '0;
          rx_perr_d  = rx_sync_q ^ even_parity(rx_shift_q);
          rx_state_d = ST_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
`endif
      ST_STOP: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = ST_IDLE;
`ifdef UART_PARITY_EN
          if (rx_sync_q && !rx_perr_q) begin
`else
          if (rx_sync_q) begin
`endif
            rx_ok_s = 1'b1;
          end else begin
            rx_bad_s = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      default: begin
        rx_state_d = ST_IDLE;
        rx_cnt_d   = '0;
      end
    endcase
  end

  // Status flags: a set in the same cycle as a clearing read wins
  always_comb begin
    rxd_d        = rx_ok_s ? rx_shift_q : rxd_q;
    tx_done_d    = tx_done_set_s | (tx_done_q & ~con_rd_s);
    rx_ready_d   = rx_ok_s | (rx_ready_q & ~rxd_rd_s);
    rx_overrun_d = (rx_ok_s & rx_ready_q) | (rx_overrun_q & ~con_rd_s);
    rx_err_d     = rx_bad_s | (rx_err_q & ~con_rd_s);
    int_en_d     = (wr && sel_con_s) ? wdata[1:0] : int_en_q;
    irq_d        = (int_en_q[0] & tx_done_q) | (int_en_q[1] & rx_ready_q);
  end

  // Two-flop synchroniser for rx plus a delayed copy for falling-edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // State, datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q   <= ST_IDLE;
      rx_state_q   <= ST_IDLE;
      tx_cnt_q     <= '0;
      rx_cnt_q     <= '0;
      tx_bit_q     <= 3'd0;
      rx_bit_q     <= 3'd0;
      tx_shift_q   <= 8'd0;
      txd_q        <= 8'd0;
      rx_shift_q   <= 8'd0;
      rxd_q        <= 8'd0;
      int_en_q     <= 2'd0;
      tx_q         <= 1'b1;
      irq_q        <= 1'b0;
      tx_done_q    <= 1'b0;
      rx_ready_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
      rx_err_q     <= 1'b0;
`ifdef UART_PARITY_EN
      rx_perr_q    <= 1'b0;
`endif
    end else begin
      tx_state_q   <= tx_state_d;
      rx_state_q   <= rx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      rx_cnt_q     <= rx_cnt_d;
      tx_bit_q     <= tx_bit_d;
      rx_bit_q     <= rx_bit_d;
      tx_shift_q   <= tx_shift_d;
      txd_q        <= txd_d;
      rx_shift_q   <= rx_shift_d;
      rxd_q        <= rxd_d;
      int_en_q     <= int_en_d;
      tx_q         <= tx_d;
      irq_q        <= irq_d;
      tx_done_q    <= tx_done_d;
      rx_ready_q   <= rx_ready_d;
      rx_overrun_q <= rx_overrun_d;
      rx_err_q     <= rx_err_d;
`ifdef UART_PARITY_EN
      rx_perr_q    <= rx_perr_d;
`endif
    end
  end

endmodule
